rx_ipv4: RTL

- IPv4 receive header parser. Sits between the Ethernet receive stage (input stream is an IPv4 datagram after MAC header/EtherType stripping) and rx_udp.
- Parses and checks the IPv4 header, and drops datagrams that fail any check.
- For accepted UDP datagrams, forwards the payload bytes only (the UDP header onward), with one cycle of latency, plus an end-of-datagram pulse that rx_udp pipelines as its own irq.

---
 rtl/rx_ipv4.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rx_ipv4.sv
// IPv4 receive header parser: validates the header of each incoming datagram
// and forwards the payload (UDP header onward) of accepted UDP datagrams with
// one cycle of latency, followed by a one-cycle end-of-datagram pulse.
module rx_ipv4 #(
   parameter int            OCT   = 8,
   parameter logic [OCT-1:0] PROTO = 8'd17
) (
   input  logic             RX_CLK,
   input  logic             rst,
   input  logic             func_en,
   input  logic [OCT*4-1:0] my_ip,
   output logic [OCT*4-1:0] rx_src_ip,
   output logic             rx_ipv4_irq,
   input  logic             rx_data_v,
   input  logic [OCT-1:0]   rx_data,
   output logic             rx_ipv4_data_v,
   output logic [OCT-1:0]   rx_ipv4_data
);

   typedef enum logic [2:0] {VER_IHL, HEADER, OPTIONS, PAYLOAD, TRAIL, DROP} state_t;

   state_t           state, state_nxt;
   logic [15:0]      cnt;
   logic [20:0]      acc, acc_sum;
   logic [3:0]       ihl;
   logic [15:0]      total_len;
   logic             mf;
   logic [12:0]      frag_off;
   logic [OCT-1:0]   proto, prev;
   logic [OCT*4-1:0] src_shadow, dst, dst_eff;
   logic [15:0]      hdr_last, min_len;
   logic [16:0]      fold1;
   logic [15:0]      fold2;
   logic             csum_ok, accept, fwd, irq_nxt, load_src;

   // Header checks evaluated against the current byte; on the last header byte
   // the final checksum word and (for IHL=5) the last dst byte come straight
   // from rx_data rather than from the registers.
   always_comb begin
      hdr_last = {10'd0, ihl, 2'b00} - 16'd1;
      min_len  = {10'd0, ihl, 2'b00} + 16'd8;
      acc_sum  = acc + 21'({prev, rx_data});
      fold1    = {1'b0, acc_sum[15:0]} + {12'd0, acc_sum[20:16]};
      fold2    = fold1[15:0] + {15'd0, fold1[16]};
      csum_ok  = (fold2 == 16'hFFFF);
      dst_eff  = (cnt == 16'd19) ? {dst[OCT*3-1:0], rx_data} : dst;
      accept   = csum_ok && (proto == PROTO) &&
                 ((dst_eff == my_ip) || (dst_eff == '1)) &&
                 !mf && (frag_off == '0) && (total_len >= min_len);
   end

   // Next-state and output-control decisions.
   always_comb begin
      state_nxt = state;
      irq_nxt   = 1'b0;
      fwd       = 1'b0;
      load_src  = 1'b0;
      if (!rx_data_v) begin
         state_nxt = VER_IHL;
         irq_nxt   = (state == TRAIL);
      end else begin
         case (state)
            VER_IHL: begin
               if (rx_data[7:4] != 4'd4 || rx_data[3:0] < 4'd5)
                  state_nxt = DROP;
               else
                  state_nxt = HEADER;
            end
            HEADER, OPTIONS: begin
               if (cnt == hdr_last) begin
                  if (accept) begin
                     state_nxt = PAYLOAD;
                     load_src  = 1'b1;
                  end else begin
                     state_nxt = DROP;
                  end
               end else if (cnt == 16'd19) begin
                  state_nxt = OPTIONS;
               end
            end
            PAYLOAD: begin
               fwd = 1'b1;
               if (cnt == total_len - 16'd1)
                  state_nxt = TRAIL;
            end
            default: state_nxt = state;
         endcase
      end
   end

   // State register.
   always_ff @(posedge RX_CLK) begin
      if (rst)
         state <= VER_IHL;
      else if (func_en)
         state <= state_nxt;
   end

   // Byte counter, checksum, header field capture and registered outputs.
   always_ff @(posedge RX_CLK) begin
      if (rst) begin
         cnt            <= '0;
         acc            <= '0;
         ihl            <= '0;
         total_len      <= '0;
         mf             <= 1'b0;
         frag_off       <= '0;
         proto          <= '0;
         prev           <= '0;
         src_shadow     <= '0;
         dst            <= '0;
         rx_src_ip      <= '0;
         rx_ipv4_irq    <= 1'b0;
         rx_ipv4_data_v <= 1'b0;
         rx_ipv4_data   <= '0;
      end else if (func_en) begin
         rx_ipv4_irq    <= irq_nxt;
         rx_ipv4_data_v <= fwd;
         if (fwd)
            rx_ipv4_data <= rx_data;
         if (load_src)
            rx_src_ip <= src_shadow;
         if (!rx_data_v) begin
            cnt <= '0;
            acc <= '0;
         end else begin
            cnt  <= cnt + 16'd1;
            prev <= rx_data;
            if (state == VER_IHL)
               ihl <= rx_data[3:0];
            if ((state == HEADER || state == OPTIONS) && cnt[0])
               acc <= acc_sum;
            if (state == HEADER) begin
               case (cnt)
                  16'd2:  total_len[15:8] <= rx_data;
                  16'd3:  total_len[7:0]  <= rx_data;
                  16'd6: begin
                     mf             <= rx_data[5];
                     frag_off[12:8] <= rx_data[4:0];
                  end
                  16'd7:  frag_off[7:0] <= rx_data;
                  16'd9:  proto <= rx_data;
                  16'd12, 16'd13, 16'd14, 16'd15:
                     src_shadow <= {src_shadow[OCT*3-1:0], rx_data};
                  16'd16, 16'd17, 16'd18, 16'd19:
                     dst <= {dst[OCT*3-1:0], rx_data};
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
